// File: rtl/md_unit_if.sv
// Port bundle between Execute-stage control and the HI/LO multiply/divide unit.
// Latency: none, wires only.
// Backpressure: none in the bundle; the consumer stalls on busy.
interface md_unit_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  // Execute-stage control drives the op; the unit answers with busy and HI/LO.
  modport master (output start, op, a, b, input busy, hi, lo);
  modport slave  (input start, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Latency: MULT_CYCLES for mult-class ops, DIV_CYCLES for divides, MTHI/MTLO visible next cycle.
// Backpressure: start is ignored while busy; the hazard unit stalls. MD_MADD_EN enables MADD/MSUB ops 7-10.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic      clk,
  input logic      reset,
  md_unit_if.slave md
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  typedef enum logic [0:0] {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic        is_mul, is_div;
  logic [63:0] acc, prod_s, prod_u, res;
  logic        a_neg, b_neg;
  logic [31:0] abs_a, abs_b, dvsr, q_mag, r_mag, quo, rem;

  assign acc    = {hi_q, lo_q};
  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Signed divide via magnitudes so the 0x80000000 / -1 case wraps cleanly.
  assign a_neg = (op_q == OP_DIV) && a_q[31];
  assign b_neg = (op_q == OP_DIV) && b_q[31];
  assign abs_a = a_neg ? (32'd0 - a_q) : a_q;
  assign abs_b = b_neg ? (32'd0 - b_q) : b_q;
  assign dvsr  = (b_q == 32'd0) ? 32'd1 : abs_b;
  assign q_mag = abs_a / dvsr;
  assign r_mag = abs_a % dvsr;
  assign quo   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem   = a_neg ? (32'd0 - r_mag) : r_mag;

  // Result written to {hi,lo} at completion, computed from latched operands.
  always_comb begin
    res = acc;
    case (op_q)
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_DIV, OP_DIVU: begin
        if (b_q != 32'd0) res = {rem, quo};
      end
`ifdef MD_MADD_EN
      OP_MADD:  res = acc + prod_s;
      OP_MADDU: res = acc + prod_u;
      OP_MSUB:  res = acc - prod_s;
      OP_MSUBU: res = acc - prod_u;
`endif
      default:  res = acc;
    endcase
  end

  // Decode incoming op into the multi-cycle classes.
  always_comb begin
    is_mul = 1'b0;
    is_div = 1'b0;
    case (md.op)
      OP_MULT, OP_MULTU: is_mul = 1'b1;
`ifdef MD_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_mul = 1'b1;
`endif
      OP_DIV, OP_DIVU:   is_div = 1'b1;
      default: ;
    endcase
  end

  // Next-state logic: accept ops only in IDLE, count down in RUN, write HI/LO on the last cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (md.start) begin
          if (is_mul || is_div) begin
            op_d    = md.op;
            a_d     = md.a;
            b_d     = md.b;
            cnt_d   = is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
            state_d = RUN;
          end else if (md.op == OP_MTHI) begin
            hi_d = md.a;
          end else if (md.op == OP_MTLO) begin
            lo_d = md.a;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          {hi_d, lo_d} = res;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and architectural registers; reset aborts any op in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign md.busy = (state_q == RUN);
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule
